ps2_rx_buffered: RTL

Parametrised PS/2 device-to-host receiver with a configurable clock glitch filter, start/stop/parity frame validation, a per-bit watchdog timeout and an output FIFO with a ready/valid read port. It sits between the PS/2 pins (already synchronised into `clk`) and the keyboard/mouse decode logic, so consumers can drain bytes at their own pace without dropping scan codes.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_sync_fifo.sv | 62 ++++++
 rtl/ps2_rx_buffered.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the buffered PS/2 receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX    = 2'd1,
        CHECK = 2'd2
    } ps2_rx_state_t;

    localparam int PS2_FRAME_BITS = 10;
    localparam int PS2_DATA_BITS  = 8;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                               input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO with a write-enable/full write side and a ready/valid read side.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         full,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             rd_fire;
    logic             wr_fire;

    assign full     = (count_reg == CW'(DEPTH));
    assign rd_valid = (count_reg != '0);
    assign rd_fire  = rd_valid & rd_ready;
    // A write into a full FIFO is still accepted when the head leaves in the same cycle.
    assign wr_fire  = wr_en & (~full | rd_fire);
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 device-to-host receiver: ps2c glitch filter, frame FSM with watchdog, output FIFO.
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_buffered
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ps2d,
    input  logic                              ps2c,
    input  logic                              rx_en,
    input  logic                              rd_ready,
    output logic                              rd_valid,
    output logic [PS2_DATA_BITS-1:0]          rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              frame_err,
    output logic                              overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES+1);

    logic [FILTER_LEN-1:0] filt_reg;
    logic                  level_reg;
    logic                  fall_reg;

    ps2_rx_state_t             state_reg, state_next;
    logic [3:0]                bit_cnt_reg, bit_cnt_next;
    logic [TW-1:0]             tcnt_reg, tcnt_next;
    logic [PS2_FRAME_BITS-1:0] sr_reg, sr_next;
    logic                      err_reg, err_next;
    logic                      ovf_reg, ovf_next;

    logic wr_en;
    logic fifo_full;
    logic rd_pop;
    logic parity_ok;
    logic frame_good;

    // Level register moves only on a unanimous window; fall is registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_reg  <= '1;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
        end else begin
            filt_reg <= {filt_reg[FILTER_LEN-2:0], ps2c};
            if (&filt_reg) begin
                level_reg <= 1'b1;
            end else if (~|filt_reg) begin
                level_reg <= 1'b0;
            end
            fall_reg <= level_reg & ~|filt_reg;
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    assign parity_ok = ps2_odd_parity_ok(sr_reg[7:0], sr_reg[8]);
`else
    logic unused_parity_bit;
    assign parity_ok         = 1'b1;
    assign unused_parity_bit = sr_reg[8];
`endif

    assign frame_good = sr_reg[9] & parity_ok;
    assign rd_pop     = rd_valid & rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            tcnt_reg    <= '0;
            sr_reg      <= '0;
            err_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            tcnt_reg    <= tcnt_next;
            sr_reg      <= sr_next;
            err_reg     <= err_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        tcnt_next    = tcnt_reg;
        sr_next      = sr_reg;
        err_next     = 1'b0;
        ovf_next     = 1'b0;
        wr_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall_reg && rx_en) begin
                    if (!ps2d) begin
                        state_next   = RX;
                        bit_cnt_next = 4'(PS2_FRAME_BITS);
                        tcnt_next    = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RX: begin
                if (fall_reg) begin
                    sr_next      = {ps2d, sr_reg[PS2_FRAME_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg - 4'd1;
                    tcnt_next    = '0;
                    if (bit_cnt_reg == 4'd1) begin
                        state_next = CHECK;
                    end
                end else if (tcnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Device stalled mid-frame: abandon the partial byte.
                    err_next   = 1'b1;
                    tcnt_next  = '0;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            CHECK: begin
                if (frame_good) begin
                    if (!fifo_full || rd_pop) begin
                        wr_en = 1'b1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end else begin
                    err_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign frame_err = err_reg;
    assign overflow  = ovf_reg;

    ps2_sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (sr_reg[PS2_DATA_BITS-1:0]),
        .full     (fifo_full),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (fifo_count)
    );

endmodule
